// File: rtl/mux_alloc.sv
// Wormhole allocator for a 2:1 router output mux: locks one input port from HEAD to TAIL,
// round-robins between packets, returns per-port grants and keeps saturating flit/packet counts.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no lock; looking for a HEAD on port 0/1; no grants issued
//  LOCK0 | mux held on port 0 until its TAIL is transferred
//  LOCK1 | mux held on port 1 until its TAIL is transferred
module mux_alloc #(
    parameter int DATAW = 64,
    parameter int TYPEW = 2,
    parameter int SELW  = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata_0,
    input  logic             ivalid_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic             ivalid_1,
    input  logic             ordy,
    output logic [SELW-1:0]  sel,
    output logic             grant_0,
    output logic             grant_1,
    output logic [CNTW-1:0]  oflits,
    output logic [CNTW-1:0]  opkts,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

    logic [1:0]      r_state;
    logic            r_rr;
    logic            r_hd_pend;
    logic [SELW-1:0] r_sel;
    logic [CNTW-1:0] r_flits;
    logic [CNTW-1:0] r_pkts;
    logic            r_err;

    logic [TYPEW-1:0] w_type_0;
    logic [TYPEW-1:0] w_type_1;
    logic [TYPEW-1:0] w_gnt_type;
    logic             w_hd_0;
    logic             w_hd_1;
    logic             w_grant_0;
    logic             w_grant_1;
    logic             w_any_grant;
    logic             w_tail;
    logic             w_err_idle;
    logic             w_err_lock;
    logic [1:0]       w_state_nxt;
    logic [SELW-1:0]  w_sel_nxt;

    assign w_type_0 = idata_0[DATAW-1 -: TYPEW];
    assign w_type_1 = idata_1[DATAW-1 -: TYPEW];
    assign w_hd_0   = ivalid_0 & (w_type_0 == T_HEAD);
    assign w_hd_1   = ivalid_1 & (w_type_1 == T_HEAD);

    assign w_grant_0   = (r_state == S_LOCK0) & ivalid_0 & ordy;
    assign w_grant_1   = (r_state == S_LOCK1) & ivalid_1 & ordy;
    assign w_any_grant = w_grant_0 | w_grant_1;
    assign w_gnt_type  = w_grant_0 ? w_type_0 : w_type_1;
    assign w_tail      = w_any_grant & (w_gnt_type == T_TAIL);

    assign w_err_idle = (r_state == S_IDLE) &
                        ((ivalid_0 & ((w_type_0 == T_DATA) | (w_type_0 == T_TAIL))) |
                         (ivalid_1 & ((w_type_1 == T_DATA) | (w_type_1 == T_TAIL))));
    // The HEAD that opened the lock is the one legal HEAD transfer; any later HEAD is a protocol error.
    assign w_err_lock = w_any_grant &
                        ((w_gnt_type == T_NONE) | ((w_gnt_type == T_HEAD) & ~r_hd_pend));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hd_0 & w_hd_1)
                    w_state_nxt = r_rr ? S_LOCK1 : S_LOCK0;
                else if (w_hd_0)
                    w_state_nxt = S_LOCK0;
                else if (w_hd_1)
                    w_state_nxt = S_LOCK1;
            end
            S_LOCK0, S_LOCK1: begin
                if (w_tail)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_nxt    = '0;
        w_sel_nxt[0] = (w_state_nxt == S_LOCK0);
        w_sel_nxt[1] = (w_state_nxt == S_LOCK1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_rr      <= 1'b0;
            r_hd_pend <= 1'b1;
            r_flits   <= '0;
            r_pkts    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            if (w_tail)
                r_rr <= w_grant_0;
            if (r_state == S_IDLE)
                r_hd_pend <= 1'b1;
            else if (w_any_grant)
                r_hd_pend <= 1'b0;
            if (w_any_grant && (r_flits != '1))
                r_flits <= r_flits + 1'b1;
            if (w_tail && (r_pkts != '1))
                r_pkts <= r_pkts + 1'b1;
            if (w_err_idle | w_err_lock)
                r_err <= 1'b1;
        end
    end

    assign sel     = r_sel;
    assign grant_0 = w_grant_0;
    assign grant_1 = w_grant_1;
    assign oflits  = r_flits;
    assign opkts   = r_pkts;
    assign err     = r_err;

endmodule

// File: tb/tb_mux_alloc.sv
// Directed bench for mux_alloc: a cycle table of arbitration/backpressure vectors plus
// hand sequences for long packets, protocol errors, mid-packet reset and counter saturation.
module tb_mux_alloc;

    localparam int DATAW = 64;
    localparam logic [1:0] TN = 2'd0, TH = 2'd1, TD = 2'd2, TT = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATAW-1:0] idata_0, idata_1;
    logic             ivalid_0, ivalid_1, ordy;
    logic [4:0]       sel, sel_s;
    logic             grant_0, grant_1, grant_0_s, grant_1_s;
    logic [15:0]      oflits, opkts;
    logic [3:0]       oflits_s, opkts_s;
    logic             err, err_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_alloc #(.DATAW(DATAW), .TYPEW(2), .SELW(5), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .idata_0(idata_0), .ivalid_0(ivalid_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1),
        .ordy(ordy), .sel(sel), .grant_0(grant_0), .grant_1(grant_1),
        .oflits(oflits), .opkts(opkts), .err(err)
    );

    // Narrow-counter copy on the same stimulus, used to see saturation quickly.
    mux_alloc #(.DATAW(DATAW), .TYPEW(2), .SELW(5), .CNTW(4)) dut_s (
        .clk(clk), .rst(rst),
        .idata_0(idata_0), .ivalid_0(ivalid_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1),
        .ordy(ordy), .sel(sel_s), .grant_0(grant_0_s), .grant_1(grant_1_s),
        .oflits(oflits_s), .opkts(opkts_s), .err(err_s)
    );

    typedef struct {
        logic       v0;
        logic [1:0] t0;
        logic       v1;
        logic [1:0] t1;
        logic       rdy;
        logic [1:0] sel;
        logic       g0;
        logic       g1;
        logic [15:0] fl;
        logic [15:0] pk;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] t0,
                         input logic v1, input logic [1:0] t1, input logic rdy);
        @(negedge clk);
        ivalid_0 = v0;
        idata_0  = {t0, 62'({$urandom, $urandom})};
        ivalid_1 = v1;
        idata_1  = {t1, 62'({$urandom, $urandom})};
        ordy     = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ivalid_0 = 1'b0;
        ivalid_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ivalid_0 = 1'b0; ivalid_1 = 1'b0; ordy = 1'b1;
        idata_0 = '0; idata_1 = '0;

        //              v0 t0  v1 t1  rdy sel    g0 g1 fl  pk
        tbl[0]  = '{1'b1, TH, 1'b1, TH, 1'b1, 2'b00, 1'b0, 1'b0, 16'd0,  16'd0};
        tbl[1]  = '{1'b1, TH, 1'b1, TH, 1'b1, 2'b01, 1'b1, 1'b0, 16'd0,  16'd0};
        tbl[2]  = '{1'b1, TD, 1'b1, TH, 1'b1, 2'b01, 1'b1, 1'b0, 16'd1,  16'd0};
        tbl[3]  = '{1'b1, TD, 1'b1, TH, 1'b0, 2'b01, 1'b0, 1'b0, 16'd2,  16'd0};
        tbl[4]  = '{1'b1, TD, 1'b1, TH, 1'b0, 2'b01, 1'b0, 1'b0, 16'd2,  16'd0};
        tbl[5]  = '{1'b1, TT, 1'b1, TH, 1'b1, 2'b01, 1'b1, 1'b0, 16'd2,  16'd0};
        tbl[6]  = '{1'b0, TN, 1'b1, TH, 1'b1, 2'b00, 1'b0, 1'b0, 16'd3,  16'd1};
        tbl[7]  = '{1'b0, TN, 1'b1, TH, 1'b1, 2'b10, 1'b0, 1'b1, 16'd3,  16'd1};
        tbl[8]  = '{1'b0, TN, 1'b1, TD, 1'b1, 2'b10, 1'b0, 1'b1, 16'd4,  16'd1};
        tbl[9]  = '{1'b1, TH, 1'b0, TD, 1'b1, 2'b10, 1'b0, 1'b0, 16'd5,  16'd1};
        tbl[10] = '{1'b1, TH, 1'b1, TT, 1'b1, 2'b10, 1'b0, 1'b1, 16'd5,  16'd1};
        tbl[11] = '{1'b1, TH, 1'b0, TN, 1'b1, 2'b00, 1'b0, 1'b0, 16'd6,  16'd2};
        tbl[12] = '{1'b1, TH, 1'b1, TH, 1'b1, 2'b01, 1'b1, 1'b0, 16'd6,  16'd2};
        tbl[13] = '{1'b1, TT, 1'b1, TH, 1'b1, 2'b01, 1'b1, 1'b0, 16'd7,  16'd2};
        tbl[14] = '{1'b1, TH, 1'b1, TH, 1'b1, 2'b00, 1'b0, 1'b0, 16'd8,  16'd3};
        tbl[15] = '{1'b1, TH, 1'b1, TH, 1'b1, 2'b10, 1'b0, 1'b1, 16'd8,  16'd3};
        tbl[16] = '{1'b1, TH, 1'b1, TT, 1'b1, 2'b10, 1'b0, 1'b1, 16'd9,  16'd3};
        tbl[17] = '{1'b1, TH, 1'b0, TN, 1'b1, 2'b00, 1'b0, 1'b0, 16'd10, 16'd4};
        tbl[18] = '{1'b1, TH, 1'b0, TN, 1'b1, 2'b01, 1'b1, 1'b0, 16'd10, 16'd4};
        tbl[19] = '{1'b1, TT, 1'b0, TN, 1'b1, 2'b01, 1'b1, 1'b0, 16'd11, 16'd4};
        tbl[20] = '{1'b0, TN, 1'b0, TN, 1'b1, 2'b00, 1'b0, 1'b0, 16'd12, 16'd5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grants", {30'd0, grant_1, grant_0}, 32'd0);
        chk("rst_oflits", 32'(oflits), 32'd0);
        chk("rst_opkts", 32'(opkts), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Arbitration, round-robin, backpressure and bubble table
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v0, tbl[i].t0, tbl[i].v1, tbl[i].t1, tbl[i].rdy);
            chk($sformatf("tbl%0d_sel", i), 32'(sel), {27'd0, 3'd0, tbl[i].sel});
            chk($sformatf("tbl%0d_g0", i), 32'(grant_0), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d_g1", i), 32'(grant_1), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d_fl", i), 32'(oflits), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_pk", i), 32'(opkts), 32'(tbl[i].pk));
            chk($sformatf("tbl%0d_fls", i), 32'(oflits_s), 32'(tbl[i].fl[3:0]));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
        end

        // Long packet on port 1: HEAD + 20 DATA + TAIL
        do_reset();
        drive(1'b0, TN, 1'b1, TH, 1'b1);
        chk("long_bubble_sel", 32'(sel), 32'd0);
        chk("long_bubble_g1", 32'(grant_1), 32'd0);
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, TN, 1'b1, (i == 0) ? TH : ((i == 21) ? TT : TD), 1'b1);
            chk($sformatf("long%0d_sel", i), 32'(sel), 32'd2);
            chk($sformatf("long%0d_g", i), {30'd0, grant_1, grant_0}, 32'd2);
        end
        drive(1'b0, TN, 1'b0, TN, 1'b1);
        chk("long_end_sel", 32'(sel), 32'd0);
        chk("long_end_oflits", 32'(oflits), 32'd22);
        chk("long_end_opkts", 32'(opkts), 32'd1);
        chk("long_end_oflits_sat", 32'(oflits_s), 32'hF);
        chk("long_end_opkts_s", 32'(opkts_s), 32'd1);
        chk("long_end_err", 32'(err), 32'd0);

        // DATA in IDLE sets a sticky error
        drive(1'b1, TD, 1'b0, TN, 1'b1);
        chk("idle_data_g0", 32'(grant_0), 32'd0);
        drive(1'b0, TN, 1'b0, TN, 1'b1);
        chk("idle_data_err", 32'(err), 32'd1);
        chk("idle_data_sel", 32'(sel), 32'd0);
        repeat (3) drive(1'b0, TN, 1'b0, TN, 1'b1);
        chk("idle_data_err_sticky", 32'(err), 32'd1);
        do_reset();
        #1;
        chk("err_cleared", 32'(err), 32'd0);

        // Second HEAD inside a lock: error, but the lock continues to the TAIL
        drive(1'b1, TH, 1'b0, TN, 1'b1);
        drive(1'b1, TH, 1'b0, TN, 1'b1);
        chk("hh_first_g0", 32'(grant_0), 32'd1);
        drive(1'b1, TH, 1'b0, TN, 1'b1);
        chk("hh_no_err_yet", 32'(err), 32'd0);
        chk("hh_second_g0", 32'(grant_0), 32'd1);
        drive(1'b1, TT, 1'b0, TN, 1'b1);
        chk("hh_err", 32'(err), 32'd1);
        chk("hh_lock_held", 32'(sel), 32'd1);
        drive(1'b0, TN, 1'b0, TN, 1'b1);
        chk("hh_idle_sel", 32'(sel), 32'd0);
        chk("hh_pkts", 32'(opkts), 32'd1);

        // Reset in LOCK1 mid-packet
        do_reset();
        drive(1'b0, TN, 1'b1, TH, 1'b1);
        drive(1'b0, TN, 1'b1, TH, 1'b1);
        drive(1'b0, TN, 1'b1, TD, 1'b1);
        chk("midrst_locked", 32'(sel), 32'd2);
        chk("midrst_pre_fl", 32'(oflits), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_g1", 32'(grant_1), 32'd0);
        chk("midrst_oflits", 32'(oflits), 32'd0);
        chk("midrst_opkts", 32'(opkts), 32'd0);
        drive(1'b0, TN, 1'b0, TN, 1'b1);
        chk("midrst_idle", 32'(sel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
